// File: rtl/katadc_config_sched_if.sv
// Handshake bundle between the config scheduler, its software master and the
// 3-wire config engine. The master modport is the scheduler's view.
interface katadc_config_sched_if;
  logic        sw_req;
  logic [3:0]  sw_addr;
  logic [15:0] sw_data;
  logic        sw_ack;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_start;
  logic        cfg_done;

  modport master (
    input  sw_req, sw_addr, sw_data, cfg_done,
    output sw_ack, cfg_addr, cfg_data, cfg_start
  );

  modport slave (
    output sw_req, sw_addr, sw_data, cfg_done,
    input  sw_ack, cfg_addr, cfg_data, cfg_start
  );
endinterface

// File: rtl/katadc_config_sched.sv
// KATADC config scheduler: replays a built-in register table after reset and
// arbitrates software writes onto a 3-wire config engine port.
module katadc_config_sched #(
  parameter int                        AUTOCONFIG  = 1,
  parameter int                        NUM_ENTRIES = 4,
  parameter int                        INIT_DELAY  = 255,
  parameter logic [4*NUM_ENTRIES-1:0]  AC_ADDR     = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [16*NUM_ENTRIES-1:0] AC_DATA     = {16'h807F, 16'h007F, 16'hBAFF, 16'h7FFF}
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst_n,
  katadc_config_sched_if.master bus,
  input  logic                 ac_rerun,
  output logic                 ac_done,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {INIT_WAIT, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  ac_idx_q, ac_idx_d;
  logic        ac_pending_q, ac_pending_d;
  logic        ac_done_q, ac_done_d;
  logic        cfg_start_q, cfg_start_d;
  logic        sw_ack_q, sw_ack_d;
  logic [3:0]  cfg_addr_q, cfg_addr_d;
  logic [15:0] cfg_data_q, cfg_data_d;
  logic        cfg_err_q, cfg_err_d;
  logic        tbl_txn_q, tbl_txn_d;
  logic [1:0]  to_cnt_q, to_cnt_d;
  logic        sw_req_q, sw_req_d;
  logic [3:0]  sw_addr_q, sw_addr_d;
  logic [15:0] sw_data_q, sw_data_d;

  logic        rerun;
  logic        txn_end;
  logic [3:0]  sel_idx;
  logic [3:0]  tbl_addr [16];
  logic [15:0] tbl_data [16];

  // Table padded to 16 slots so a 4-bit index always lands on a defined entry.
  for (genvar gi = 0; gi < 16; gi++) begin : g_tbl
    if (gi < NUM_ENTRIES) begin : g_used
      assign tbl_addr[gi] = AC_ADDR[gi*4 +: 4];
      assign tbl_data[gi] = AC_DATA[gi*16 +: 16];
    end else begin : g_unused
      assign tbl_addr[gi] = '0;
      assign tbl_data[gi] = '0;
    end
  end

  assign rerun   = (AUTOCONFIG != 0) && ac_rerun;
  assign sel_idx = rerun ? 4'd0 : ac_idx_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ac_idx_d     = ac_idx_q;
    ac_pending_d = ac_pending_q;
    ac_done_d    = ac_done_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_data_d   = cfg_data_q;
    cfg_err_d    = cfg_err_q;
    tbl_txn_d    = tbl_txn_q;
    to_cnt_d     = to_cnt_q;
    cfg_start_d  = 1'b0;
    sw_ack_d     = 1'b0;
    txn_end      = 1'b0;
    sw_req_d     = bus.sw_req;
    sw_addr_d    = bus.sw_addr;
    sw_data_d    = bus.sw_data;

    // A rerun also disowns an in-flight table transfer so its completion
    // does not advance the freshly zeroed index.
    if (rerun) begin
      ac_pending_d = 1'b1;
      ac_done_d    = 1'b0;
      ac_idx_d     = 4'd0;
      tbl_txn_d    = 1'b0;
    end

    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      IDLE: begin
        if (ac_pending_q || rerun) begin
          cfg_addr_d  = tbl_addr[sel_idx];
          cfg_data_d  = tbl_data[sel_idx];
          tbl_txn_d   = 1'b1;
          cfg_start_d = 1'b1;
          state_d     = ISSUE;
        end else if (sw_req_q) begin
          cfg_addr_d  = sw_addr_q;
          cfg_data_d  = sw_data_q;
          tbl_txn_d   = 1'b0;
          cfg_start_d = 1'b1;
          sw_ack_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_d = 2'd0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.cfg_done) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == 2'd3) begin
          cfg_err_d = 1'b1;
          txn_end   = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.cfg_done) begin
          txn_end = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_WAIT;
    endcase

    if (txn_end && tbl_txn_q && !rerun) begin
      tbl_txn_d = 1'b0;
      if (ac_idx_q == 4'(NUM_ENTRIES - 1)) begin
        ac_idx_d     = 4'd0;
        ac_pending_d = 1'b0;
        ac_done_d    = 1'b1;
      end else begin
        ac_idx_d = ac_idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q      <= INIT_WAIT;
      cnt_q        <= 16'(INIT_DELAY);
      ac_idx_q     <= 4'd0;
      ac_pending_q <= (AUTOCONFIG != 0);
      ac_done_q    <= (AUTOCONFIG == 0);
      cfg_start_q  <= 1'b0;
      sw_ack_q     <= 1'b0;
      cfg_addr_q   <= 4'd0;
      cfg_data_q   <= 16'd0;
      cfg_err_q    <= 1'b0;
      tbl_txn_q    <= 1'b0;
      to_cnt_q     <= 2'd0;
      sw_req_q     <= 1'b0;
      sw_addr_q    <= 4'd0;
      sw_data_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ac_idx_q     <= ac_idx_d;
      ac_pending_q <= ac_pending_d;
      ac_done_q    <= ac_done_d;
      cfg_start_q  <= cfg_start_d;
      sw_ack_q     <= sw_ack_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_data_q   <= cfg_data_d;
      cfg_err_q    <= cfg_err_d;
      tbl_txn_q    <= tbl_txn_d;
      to_cnt_q     <= to_cnt_d;
      sw_req_q     <= sw_req_d;
      sw_addr_q    <= sw_addr_d;
      sw_data_q    <= sw_data_d;
    end
  end

  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.cfg_start = cfg_start_q;
  assign bus.sw_ack    = sw_ack_q;
  assign ac_done       = ac_done_q;
  assign cfg_err       = cfg_err_q;
  assign busy          = (state_q != IDLE);

endmodule
